sram_ctrl: RTL and testbench
============================

# sram_ctrl

Multi-cycle data-memory controller between the MEM stage and an off-chip 32-bit asynchronous SRAM. It replaces the single-cycle data memory. It takes the MEM stage's address (ALU_res), store data (val_rm) and read/write enables, and runs a fixed-wait-state SRAM access. While an access is in flight it drives `ready` low so the hazard/freeze logic stalls the whole pipeline.

## Interface
Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM word-address width.
- WAIT_CYCLES, 5: SRAM strobe cycles per access; minimum 1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_R_EN  in  1  load request from the EXE/MEM register.
- MEM_W_EN  in  1  store request from the EXE/MEM register.
- ALU_res  in  32  byte address.
- val_rm  in  32  store data.
- DATA  out  32  load result; registered.
- ready  out  1  high means the pipeline may advance; low means freeze.
- addr_err  out  1  one-cycle pulse on an illegal address. Tied 0 unless SRAM_RANGE_CHECK_EN is defined.
- SRAM_ADDR  out  SRAM_AW  word address.
- SRAM_DQ_out  out  32  write data.
- SRAM_DQ_oe  out  1  drive enable for the top-level tristate.
- SRAM_DQ_in  in  32  read data.
- SRAM_WE_N  out  1  write strobe, active-low.
- SRAM_OE_N  out  1  output enable, active-low.

## Operation
FSM states: IDLE, ACCESS, DONE.
- **Request:** req = MEM_R_EN | MEM_W_EN.
- **Priority:** if both enables are high, the access is a write.
- **IDLE:**
  - On req, latch SRAM_ADDR = ((ALU_res − ADDR_BASE) >> 2)[SRAM_AW−1:0], latch SRAM_DQ_out = val_rm, latch the op, clear the counter, then go to ACCESS.
  - Without req, stay in IDLE.
- **ACCESS:**
  - Write: SRAM_WE_N = 0 and SRAM_DQ_oe = 1.
  - Read: SRAM_OE_N = 0.
  - The counter increments each cycle.
  - When counter == WAIT_CYCLES−1: on a read, capture SRAM_DQ_in into DATA; then go to DONE.
- **DONE:** strobes are deasserted; go unconditionally to IDLE next cycle. The pipeline advances at the clock edge ending DONE.
- **Ready:** ready = (IDLE & ~req) | DONE. This is combinational on req, so a request stalls in the same cycle it appears.
- **DATA:** holds its last read value across writes and idle cycles.
- **Outputs:** SRAM_WE_N and SRAM_OE_N are decoded from registered state/op. They are glitch-free and never both low.
- **Reset:**
  - Values: state IDLE, counter 0, DATA 0, SRAM_ADDR 0, SRAM_DQ_out 0, SRAM_DQ_oe 0, SRAM_WE_N 1, SRAM_OE_N 1, addr_err 0.
  - `ready` is 1 while in reset, since state is IDLE and no request is assumed valid.
  - Reset asserted mid-access aborts immediately and asynchronously; a partially written word is undefined.

## Timing
- Latency: a request first seen in cycle 0 strobes in cycles 1..WAIT_CYCLES and reaches DONE in cycle WAIT_CYCLES+1.
- `ready` is low for cycles 0..WAIT_CYCLES, i.e. WAIT_CYCLES+1 stall cycles.
- Load data is valid on DATA from the DONE cycle and held afterwards.
- Back-to-back accesses: the next request is seen in IDLE at cycle WAIT_CYCLES+2. There is no idle gap beyond that single IDLE cycle.
- Request inputs must be stable from the request cycle through DONE; the freeze guarantees this.

## Configuration
- SRAM_RANGE_CHECK_EN defined:
  - An address is illegal if ALU_res < ADDR_BASE, or if the word index ≥ 2^SRAM_AW, or if ALU_res[1:0] ≠ 0.
  - An illegal request goes IDLE→DONE with no strobes.
  - addr_err = 1 for the DONE cycle.
  - On a read, DATA = 0.
  - The stall is 1 cycle.
- SRAM_RANGE_CHECK_EN undefined: no check is made; the address is truncated and wraps; ALU_res[1:0] is ignored; addr_err is constant 0.

## Structure
- Package sram_pkg holds:
  - typedef sram_state_t {IDLE, ACCESS, DONE};
  - default constants SRAM_ADDR_BASE = 1024, SRAM_WAIT_DEFAULT = 5, SRAM_AW_DEFAULT = 18.
- One sub-module, sram_wait_cnt: a clear/enable counter that outputs a terminal-count flag at WAIT_CYCLES−1. It takes the same async active-low reset.
- The tristate buffer lives at the top level, not in this block.

## Test plan
All scenarios use default parameters.
- **Store:** store 0xDEADBEEF to 1032 → SRAM_ADDR=2, SRAM_DQ_out=0xDEADBEEF, SRAM_WE_N low in cycles 1–5, ready low in cycles 0–5 and high in cycle 6.
- **Load:** load from 1032 with the SRAM model returning 0xDEADBEEF → SRAM_OE_N low in cycles 1–5, DATA=0xDEADBEEF in cycle 6, WE_N stays high.
- **Idle:** no request for 10 cycles → ready=1 throughout, all strobes high, DATA unchanged.
- **Back-to-back:** load then store → second access seen in cycle 7, strobes in cycles 8–12, ready high in cycle 13.
- **Reset mid-access:** rst low in cycle 3 of a store → SRAM_WE_N=1 and SRAM_DQ_oe=0 immediately; after release, state is IDLE and DATA=0.
- **Range check:** with SRAM_RANGE_CHECK_EN, load from 1000 → no strobes, cycle 1 shows ready=1, addr_err=1, DATA=0. Without the macro → a normal 6-cycle access to wrapped word 0x3FFFA.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared state type, default constants and address helpers for the SRAM data-memory controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sram_state_t;

  localparam int SRAM_ADDR_BASE    = 1024;
  localparam int SRAM_WAIT_DEFAULT = 5;
  localparam int SRAM_AW_DEFAULT   = 18;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte offset of a CPU address from the start of the SRAM window.
  function automatic logic [31:0] byte_offset(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state counter: clear/enable counter with a terminal-count flag at WAIT_CYCLES-1.
module sram_wait_cnt import sram_pkg::*; #(
  parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_width(WAIT_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle MEM-stage controller for a 32-bit asynchronous SRAM with fixed wait states.
// Optional address range checking is enabled by defining SRAM_RANGE_CHECK_EN.
module sram_ctrl import sram_pkg::*; #(
  parameter int ADDR_BASE   = SRAM_ADDR_BASE,
  parameter int SRAM_AW     = SRAM_AW_DEFAULT,
  parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        DATA,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [31:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [31:0]        SRAM_DQ_in,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam logic [31:0] BASE_W = 32'(ADDR_BASE);

  sram_state_t r_state;
  sram_state_t w_next;

  logic               r_op_wr;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [31:0]        r_dq_out;
  logic [31:0]        r_data;

  logic        w_req;
  logic        w_start;
  logic        w_tc;
  logic        w_illegal;
  logic        w_rd_capture;
  logic        w_rd_zero;
  logic [31:0] w_off;

  assign w_req   = MEM_R_EN | MEM_W_EN;
  assign w_start = (r_state == IDLE) & w_req;
  assign w_off   = byte_offset(ALU_res, BASE_W);

`ifdef SRAM_RANGE_CHECK_EN
  logic r_err;
  logic w_unused_bits;

  // Below the window, past the last SRAM word, or not word aligned.
  assign w_illegal     = (ALU_res < BASE_W) | (|w_off[31:SRAM_AW+2]) | (|ALU_res[1:0]);
  assign w_unused_bits = ^w_off[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= w_illegal;
    end
  end

  assign addr_err = (r_state == DONE) & r_err;
`else
  logic w_unused_bits;

  // Without checking the word index simply wraps inside the SRAM.
  assign w_illegal     = 1'b0;
  assign w_unused_bits = ^{w_off[31:SRAM_AW+2], w_off[1:0]};
  assign addr_err      = 1'b0;
`endif

  sram_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == IDLE),
    .i_en  (r_state == ACCESS),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next = w_illegal ? DONE : ACCESS;
      ACCESS:  if (w_tc) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes decode only registered state/op so they cannot glitch on input changes.
  always_comb begin
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_DQ_oe = 1'b0;
    ready      = 1'b0;
    unique case (r_state)
      IDLE:   ready = ~w_req;
      ACCESS: begin
        if (r_op_wr) begin
          SRAM_WE_N  = 1'b0;
          SRAM_DQ_oe = 1'b1;
        end else begin
          SRAM_OE_N  = 1'b0;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (!rst) ready = 1'b1;
  end

  // Request latch: address, store data and op are frozen for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_wr     <= 1'b0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else if (w_start) begin
      r_op_wr     <= MEM_W_EN;
      r_sram_addr <= w_off[SRAM_AW+1:2];
      r_dq_out    <= val_rm;
    end
  end

  assign w_rd_capture = (r_state == ACCESS) & w_tc & ~r_op_wr;
  assign w_rd_zero    = w_start & w_illegal & ~MEM_W_EN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (w_rd_capture) begin
      r_data <= SRAM_DQ_in;
    end else if (w_rd_zero) begin
      r_data <= '0;
    end
  end

  assign DATA        = r_data;
  assign SRAM_ADDR   = r_sram_addr;
  assign SRAM_DQ_out = r_dq_out;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: directed scenarios plus random loads/stores against a word-level memory model.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int WAIT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [31:0]   ALU_res, val_rm;
  logic [31:0]   DATA;
  logic          ready, addr_err;
  logic [AW-1:0] SRAM_ADDR;
  logic [31:0]   SRAM_DQ_out;
  logic          SRAM_DQ_oe;
  logic [31:0]   SRAM_DQ_in = 32'h0;
  logic          SRAM_WE_N, SRAM_OE_N;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] word;
    logic [31:0]   wdata;
    logic [31:0]   data;
    int            stall;
    int            nstb;
    int            err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sram_mem [logic [AW-1:0]];
  logic [31:0] ref_mem  [logic [AW-1:0]];
  logic [31:0] pred_data = 32'h0;
  logic [31:0] mdl_data  = 32'h0;

  sram_ctrl #(
    .ADDR_BASE   (BASE),
    .SRAM_AW     (AW),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .ALU_res     (ALU_res),
    .val_rm      (val_rm),
    .DATA        (DATA),
    .ready       (ready),
    .addr_err    (addr_err),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_out (SRAM_DQ_out),
    .SRAM_DQ_oe  (SRAM_DQ_oe),
    .SRAM_DQ_in  (SRAM_DQ_in),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_OE_N   (SRAM_OE_N)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-up contents of a word the bench has never written.
  function automatic logic [31:0] fill(input logic [AW-1:0] w);
    return {w[13:0], w} ^ 32'h5A5A_0000;
  endfunction

  // Word-level reference: what one request should do to the memory and to DATA.
  function automatic exp_t predict(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] widx;
    bit          legal;
    widx    = (addr - 32'(BASE)) >> 2;
    legal   = 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
    legal   = (addr >= 32'(BASE)) && (widx < 32'(1 << AW)) && (addr[1:0] == 2'b00);
`endif
    e.wr    = wr;
    e.word  = widx[AW-1:0];
    e.wdata = wd;
    if (!legal) begin
      e.stall = 1;
      e.nstb  = 0;
      e.err   = 1;
      e.data  = wr ? pred_data : 32'h0;
    end else begin
      e.stall = WAIT + 1;
      e.nstb  = WAIT;
      e.err   = 0;
      if (wr) begin
        ref_mem[e.word] = wd;
        e.data = pred_data;
      end else begin
        e.data = ref_mem.exists(e.word) ? ref_mem[e.word] : fill(e.word);
      end
    end
    pred_data = e.data;
    return e;
  endfunction

  // Asynchronous SRAM model, sampled away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst && !SRAM_WE_N && SRAM_DQ_oe) sram_mem[SRAM_ADDR] = SRAM_DQ_out;
    if (!SRAM_OE_N)
      SRAM_DQ_in = sram_mem.exists(SRAM_ADDR) ? sram_mem[SRAM_ADDR] : fill(SRAM_ADDR);
    else
      SRAM_DQ_in = 32'hBAD0_BAD0;
  end

  // Monitor: accumulates one transaction and checks it against the scoreboard when ready rises.
  initial begin
    int            cyc, nwe, noe, first, last, nerr;
    bit            in_txn;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_dq;
    exp_t          e;
    in_txn = 0; cyc = 0; nwe = 0; noe = 0; first = -1; last = -1; nerr = 0;
    cap_addr = '0; cap_dq = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 0;
        sb.delete();
      end else if (MEM_R_EN || MEM_W_EN) begin
        if (!in_txn) begin
          in_txn = 1; cyc = 0; nwe = 0; noe = 0; first = -1; last = -1; nerr = 0;
        end
        chk("strobe_exclusive", 32'(SRAM_WE_N | SRAM_OE_N), 32'd1);
        if (!SRAM_WE_N) begin
          nwe++;
          chk("dq_oe_during_write", 32'(SRAM_DQ_oe), 32'd1);
        end
        if (!SRAM_OE_N) noe++;
        if (!SRAM_WE_N || !SRAM_OE_N) begin
          if (first < 0) first = cyc;
          last     = cyc;
          cap_addr = SRAM_ADDR;
          cap_dq   = SRAM_DQ_out;
        end
        if (addr_err) nerr++;
        if (ready) begin
          in_txn = 0;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: transaction completed with nothing expected at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("stall_cycles", cyc, e.stall);
            chk(e.wr ? "we_strobe_cycles" : "oe_strobe_cycles", e.wr ? nwe : noe, e.nstb);
            chk("wrong_strobe_cycles", e.wr ? noe : nwe, 0);
            chk("addr_err_cycles", nerr, e.err);
            chk("data_out", DATA, e.data);
            if (e.nstb > 0) begin
              chk("first_strobe_cycle", first, 1);
              chk("last_strobe_cycle", last, WAIT);
              chk("sram_addr", 32'(cap_addr), 32'(e.word));
              if (e.wr) chk("sram_wdata", cap_dq, e.wdata);
            end
            mdl_data = e.data;
          end
        end else begin
          cyc++;
        end
      end else begin
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("idle_oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("idle_dq_oe", 32'(SRAM_DQ_oe), 32'd0);
        chk("idle_data_hold", DATA, mdl_data);
      end
    end
  end

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   budget;
    e        = predict(wr, addr, wd);
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    ALU_res  = addr;
    val_rm   = wd;
    sb.push_back(e);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!ready && budget < 50);
    n_chk++;
    if (!ready) begin
      n_fail++;
      $display("FAIL txn_timeout: ready %0b after %0d cycles, expected 1", ready, budget);
    end
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [AW-1:0] w;
    logic [31:0]   a;
    int            r;
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_res = '0; val_rm = '0;
    #3;
    chk("rst_data", DATA, 32'h0);
    chk("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
    chk("rst_dq_out", SRAM_DQ_out, 32'h0);
    chk("rst_dq_oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
    do_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    idle(10);
    do_txn(1'b1, 1'b0, 32'd1040, 32'h0);
    do_txn(1'b0, 1'b1, 32'd1044, 32'hCAFE_F00D);
    do_txn(1'b1, 1'b1, 32'd1048, 32'h0BAD_C0DE);
    do_txn(1'b1, 1'b0, 32'd1048, 32'h0);
    do_txn(1'b1, 1'b0, 32'd1000, 32'h0);
    idle(2);
    do_txn(1'b0, 1'b1, 32'(BASE) + 32'(((1 << AW) - 1) * 4), 32'h7777_1111);
    do_txn(1'b1, 1'b0, 32'(BASE) + 32'(((1 << AW) - 1) * 4), 32'h0);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 7));
      w = AW'($urandom_range(0, 15));
      a = 32'(BASE) + {12'h0, w, 2'b00};
      if ($urandom_range(0, 7) == 0) a = $urandom();
      do_txn(r != 1 && r != 2 && r != 3, r <= 3, a, $urandom());
      idle(int'($urandom_range(0, 2)));
    end

    // Reset in the third strobe cycle of a store.
    MEM_W_EN = 1'b1; ALU_res = 32'd1052; val_rm = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort_dq_oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    MEM_W_EN = 1'b0;
    sram_mem.delete(AW'(7));
    ref_mem.delete(AW'(7));
    pred_data = 32'h0;
    mdl_data  = 32'h0;
    @(negedge clk);
    chk("abort_data", DATA, 32'h0);
    chk("abort_sram_addr", 32'(SRAM_ADDR), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_abort_ready", 32'(ready), 32'd1);
    chk("post_abort_data", DATA, 32'h0);
    do_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    do_txn(1'b1, 1'b0, 32'd1052, 32'h0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
